// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty decoder: default widths, FSM state codes
// and stuck-input codes.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned DUTY_W_DEF = 8;

  typedef logic [1:0] state_t;
  localparam state_t S_SEEK = 2'd0;
  localparam state_t S_HIGH = 2'd1;
  localparam state_t S_LOW  = 2'd2;

  typedef logic [1:0] stuck_t;
  localparam stuck_t STUCK_NONE = 2'd0;
  localparam stuck_t STUCK_LO   = 2'd1;
  localparam stuck_t STUCK_HI   = 2'd2;

endpackage

// File: rtl/pwm_frac_divider.sv
// Restoring divider producing floor(dividend * 2^DUTY_W / divisor), one quotient
// bit per cycle. Caller guarantees dividend < divisor and divisor != 0.
module pwm_frac_divider
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              start,
  input  logic [CNT_W-1:0]  dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quotient
);

  localparam int unsigned IW = $clog2(DUTY_W + 1);

  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  div;
  logic [IW-1:0]     iter;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W:0]    diff;
  logic              ge;

  // Since dividend < divisor, the upper half of dividend<<DUTY_W is the starting
  // remainder; only zeros shift in. rem_sh < 2*div, so the borrow bit alone
  // tells whether the subtraction fits.
  always_comb begin
    rem_sh = {rem, 1'b0};
    diff   = rem_sh - {1'b0, div};
    ge     = ~diff[CNT_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem      <= '0;
      div      <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem      <= ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        quotient <= {quotient[DUTY_W-2:0], ge};
        iter     <= iter - 1'b1;
        if (iter == IW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        rem      <= dividend;
        div      <= divisor;
        quotient <= '0;
        iter     <= IW'(DUTY_W);
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures an incoming PWM waveform (high time and rise-to-rise period) and
// recovers its duty code; flags inputs stuck high or low.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DUTY_W  = DUTY_W_DEF,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  high_out,
  output logic [CNT_W-1:0]  period_out,
  output logic              meas_valid,
  output logic              stuck_hi,
  output logic              stuck_lo,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(TIMEOUT);

  logic              s1, s2, s3;
  logic              rise, fall, edge_det;
  state_t            state;
  stuck_t            stuck;
  logic [CNT_W-1:0]  hi_cnt, per_cnt, idle_cnt;
  logic [CNT_W-1:0]  pend_hi, pend_per;
  logic [DUTY_W-1:0] duty_q, div_q;
  logic              div_start, div_busy, div_done, timeout;

  always_comb begin
    rise      = s2 & ~s3;
    fall      = ~s2 & s3;
    edge_det  = rise | fall;
    // An edge in the same cycle always beats the timeout.
    timeout   = (state != S_SEEK) && !edge_det &&
                ((idle_cnt >= IDLE_LIM) || (per_cnt == CNT_MAX));
    div_start = ena && (state == S_LOW) && rise && !div_busy;
    stuck_hi  = (stuck == STUCK_HI);
    stuck_lo  = (stuck == STUCK_LO);
    if (stuck == STUCK_HI)      duty_out = '1;
    else if (stuck == STUCK_LO) duty_out = '0;
    else                        duty_out = duty_q;
  end

  pwm_frac_divider #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (~ena),
    .start    (div_start),
    .dividend (hi_cnt),
    .divisor  (per_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= S_SEEK;
      stuck      <= STUCK_NONE;
      hi_cnt     <= '0;
      per_cnt    <= '0;
      idle_cnt   <= '0;
      pend_hi    <= '0;
      pend_per   <= '0;
      duty_q     <= '0;
      high_out   <= '0;
      period_out <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s1         <= pwm_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      if (!ena) begin
        state    <= S_SEEK;
        idle_cnt <= '0;
      end else begin
        if (div_done) begin
          meas_valid <= 1'b1;
          duty_q     <= div_q;
          high_out   <= pend_hi;
          period_out <= pend_per;
          overrun    <= 1'b0;
        end
        if (edge_det) stuck <= STUCK_NONE;
        if (edge_det || state == S_SEEK) idle_cnt <= '0;
        else if (idle_cnt != CNT_MAX)    idle_cnt <= idle_cnt + 1'b1;

        if (timeout) begin
          state <= S_SEEK;
          stuck <= s2 ? STUCK_HI : STUCK_LO;
        end else begin
          case (state)
            S_SEEK: begin
              if (rise) begin
                state   <= S_HIGH;
                hi_cnt  <= CNT_W'(1);
                per_cnt <= CNT_W'(1);
              end
            end
            S_HIGH: begin
              if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
              if (fall) state <= S_LOW;
              else if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
            end
            S_LOW: begin
              if (rise) begin
                // Later assignment lets a new overrun win over a same-cycle clear.
                if (div_busy) overrun <= 1'b1;
                else begin
                  pend_hi  <= hi_cnt;
                  pend_per <= per_cnt;
                end
                hi_cnt  <= CNT_W'(1);
                per_cnt <= CNT_W'(1);
                state   <= S_HIGH;
              end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + 1'b1;
              end
            end
            default: state <= S_SEEK;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: expected measurements are derived from
// the driven waveform's cycle timestamps and compared against captured results.
module tb_pwm_duty_decoder;

  localparam int CNT_W   = 16;
  localparam int DUTY_W  = 8;
  localparam int TIMEOUT = 300;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  hi;
    logic [CNT_W-1:0]  per;
  } meas_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              pwm_in = 1'b0;
  logic [DUTY_W-1:0] duty_out;
  logic [CNT_W-1:0]  high_out, period_out;
  logic              meas_valid, stuck_hi, stuck_lo, overrun;

  pwm_duty_decoder #(
    .CNT_W   (CNT_W),
    .DUTY_W  (DUTY_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .high_out   (high_out),
    .period_out (period_out),
    .meas_valid (meas_valid),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  int    mv_count = 0;
  bit    ovr_seen = 1'b0;
  bit    armed = 1'b0;
  bit    expect_on = 1'b1;
  int    rise_c = 0;
  int    fall_c = 0;
  meas_t last_exp = '0;
  meas_t mon_m;
  meas_t exp_q[$];
  meas_t obs_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mon_m.duty = duty_out;
      mon_m.hi   = high_out;
      mon_m.per  = period_out;
      obs_q.push_back(mon_m);
      mv_count++;
    end
    if (overrun === 1'b1) ovr_seen = 1'b1;
  end

  // Every pwm_in change goes through here so expected results follow real timing.
  task automatic set_pwm(input bit v);
    meas_t e;
    if (v && !pwm_in) begin
      if (armed && expect_on) begin
        e.hi   = CNT_W'(fall_c - rise_c);
        e.per  = CNT_W'(cyc - rise_c);
        e.duty = DUTY_W'(((fall_c - rise_c) << DUTY_W) / (cyc - rise_c));
        exp_q.push_back(e);
        last_exp = e;
      end
      armed  = 1'b1;
      rise_c = cyc;
    end else if (!v && pwm_in) begin
      fall_c = cyc;
    end
    pwm_in = v;
  endtask

  task automatic drive_pwm(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      set_pwm(1'b1);
      repeat (h) @(negedge clk);
      set_pwm(1'b0);
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({duty_out, high_out, period_out, meas_valid, stuck_hi, stuck_lo, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got duty=%0d hi=%0d per=%0d mv=%b sh=%b sl=%b ov=%b expected all 0",
               duty_out, high_out, period_out, meas_valid, stuck_hi, stuck_lo, overrun);
    end
    rst_n = 1'b1;
    armed = 1'b0;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
  endtask

  task automatic test_steady();
    int mv0;
    meas_t e, o;
    mv0 = mv_count;
    drive_pwm(25, 125, 4);
    repeat (20) @(negedge clk);
    checks++;
    if (mv_count - mv0 !== 3) begin
      fails++;
      $display("FAIL t1_valid_count: got %0d expected 3", mv_count - mv0);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL t1_meas_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL t1_meas: got duty=%0d hi=%0d per=%0d expected duty=%0d hi=%0d per=%0d",
                 o.duty, o.hi, o.per, e.duty, e.hi, e.per);
      end
    end
    checks++;
    if (duty_out !== 8'd51) begin
      fails++;
      $display("FAIL t1_duty_51: got %0d expected 51", duty_out);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_duty_change();
    meas_t e, o;
    drive_pwm(100, 125, 3);
    checks++;
    if (duty_out !== 8'd204) begin
      fails++;
      $display("FAIL t2_duty_204: got %0d expected 204", duty_out);
    end
    drive_pwm(50, 125, 3);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL t2_meas_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL t2_meas: got duty=%0d hi=%0d per=%0d expected duty=%0d hi=%0d per=%0d",
                 o.duty, o.hi, o.per, e.duty, e.hi, e.per);
      end
    end
    checks++;
    if (duty_out !== 8'd102) begin
      fails++;
      $display("FAIL t2_duty_102: got %0d expected 102", duty_out);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_stuck();
    int k;
    meas_t e, o;
    set_pwm(1'b1);
    k = 0;
    while (stuck_hi !== 1'b1 && k < TIMEOUT + 50) begin
      @(negedge clk);
      k++;
    end
    armed = 1'b0;
    checks++;
    if (stuck_hi !== 1'b1 || stuck_lo !== 1'b0) begin
      fails++;
      $display("FAIL t3_stuck_hi: got sh=%b sl=%b expected sh=1 sl=0", stuck_hi, stuck_lo);
    end
    checks++;
    if (duty_out !== 8'hFF) begin
      fails++;
      $display("FAIL t3_duty_ones: got %0d expected 255", duty_out);
    end
    checks++;
    if (high_out !== last_exp.hi || period_out !== last_exp.per) begin
      fails++;
      $display("FAIL t3_hold: got hi=%0d per=%0d expected hi=%0d per=%0d",
               high_out, period_out, last_exp.hi, last_exp.per);
    end
    set_pwm(1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (stuck_hi !== 1'b0 || stuck_lo !== 1'b0) begin
      fails++;
      $display("FAIL t3_stuck_clear: got sh=%b sl=%b expected 0 0", stuck_hi, stuck_lo);
    end
    drive_pwm(30, 100, 3);
    k = 0;
    while (stuck_lo !== 1'b1 && k < TIMEOUT + 50) begin
      @(negedge clk);
      k++;
    end
    armed = 1'b0;
    checks++;
    if (stuck_lo !== 1'b1 || duty_out !== 8'd0) begin
      fails++;
      $display("FAIL t3_stuck_lo: got sl=%b duty=%0d expected sl=1 duty=0", stuck_lo, duty_out);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL t3_meas_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL t3_meas: got duty=%0d hi=%0d per=%0d expected duty=%0d hi=%0d per=%0d",
                 o.duty, o.hi, o.per, e.duty, e.hi, e.per);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_overrun();
    int mv0;
    meas_t o;
    meas_t want;
    want.duty = DUTY_W'(128);
    want.hi   = CNT_W'(3);
    want.per  = CNT_W'(6);
    mv0 = mv_count;
    ovr_seen = 1'b0;
    expect_on = 1'b0;
    drive_pwm(3, 6, 12);
    expect_on = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (ovr_seen !== 1'b1) begin
      fails++;
      $display("FAIL t4_overrun_seen: got %b expected 1", ovr_seen);
    end
    checks++;
    if (mv_count - mv0 !== 6) begin
      fails++;
      $display("FAIL t4_valid_count: got %0d expected 6", mv_count - mv0);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (o !== want) begin
        fails++;
        $display("FAIL t4_meas: got duty=%0d hi=%0d per=%0d expected duty=128 hi=3 per=6",
                 o.duty, o.hi, o.per);
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL t4_overrun_cleared: got %b expected 0", overrun);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int mv0;
    meas_t e, o;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;
    obs_q.delete();
    drive_pwm(20, 50, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;
    checks++;
    if ({duty_out, high_out, period_out, meas_valid, stuck_hi, stuck_lo, overrun} !== '0) begin
      fails++;
      $display("FAIL t5_reset_outputs: got duty=%0d hi=%0d per=%0d mv=%b ov=%b expected all 0",
               duty_out, high_out, period_out, meas_valid, overrun);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL t5_pre_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete();
    obs_q.delete();
    mv0 = mv_count;
    drive_pwm(20, 50, 1);
    checks++;
    if (mv_count !== mv0) begin
      fails++;
      $display("FAIL t5_no_early_valid: got %0d expected 0", mv_count - mv0);
    end
    drive_pwm(20, 50, 1);
    checks++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      fails++;
      $display("FAIL t5_first_valid: got %0d expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL t5_meas: got duty=%0d hi=%0d per=%0d expected duty=%0d hi=%0d per=%0d",
                 o.duty, o.hi, o.per, e.duty, e.hi, e.per);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_latency_ena();
    int lat;
    int mv0;
    meas_t e, o;
    lat = -1;
    mv0 = mv_count;
    set_pwm(1'b1);
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (meas_valid === 1'b1 && lat < 0) lat = k;
    end
    checks++;
    if (lat !== DUTY_W + 3) begin
      fails++;
      $display("FAIL t6_latency: got %0d expected %0d", lat, DUTY_W + 3);
    end
    @(negedge clk);
    set_pwm(1'b0);
    repeat (20) @(negedge clk);
    expect_on = 1'b0;
    set_pwm(1'b1);
    expect_on = 1'b1;
    repeat (5) @(negedge clk);
    ena = 1'b0;
    armed = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (mv_count - mv0 !== 1) begin
      fails++;
      $display("FAIL t6_abort_no_valid: got %0d expected 1", mv_count - mv0);
    end
    checks++;
    if (duty_out !== last_exp.duty || period_out !== last_exp.per) begin
      fails++;
      $display("FAIL t6_hold: got duty=%0d per=%0d expected duty=%0d per=%0d",
               duty_out, period_out, last_exp.duty, last_exp.per);
    end
    ena = 1'b1;
    set_pwm(1'b0);
    repeat (5) @(negedge clk);
    drive_pwm(10, 40, 3);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL t6_meas_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL t6_meas: got duty=%0d hi=%0d per=%0d expected duty=%0d hi=%0d per=%0d",
                 o.duty, o.hi, o.per, e.duty, e.hi, e.per);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_change();
    test_stuck();
    test_overrun();
    test_reset_mid();
    test_latency_ena();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
